// File: rtl/boot_selector_if.sv
// Boot selector signal bundle: button inputs, pre-boot hook handshake and boot outputs.
// state_dbg mirrors the FSM state so checkers can bind to it without reaching into the design.
interface boot_selector_if;
  logic       btn_val;
  logic       btn_fall;
  logic       hook_go;
  logic       hook_rdy;
  logic       boot_req;
  logic [1:0] boot_sel;
  logic       sel_active;
  logic       led;
  logic [2:0] state_dbg;

  // hook_go/hook_rdy is a request/complete pair, not valid/ready: hook_go is a one-cycle
  // start pulse and hook_rdy (level or pulse) is honoured only while the FSM waits in HOOK.
  modport master (
    output btn_val, btn_fall, hook_rdy,
    input  hook_go, boot_req, boot_sel, sel_active, led, state_dbg
  );

  modport slave (
    input  btn_val, btn_fall, hook_rdy,
    output hook_go, boot_req, boot_sel, sel_active, led, state_dbg
  );
endinterface

// File: rtl/boot_selector.sv
// Boot image selector: a held button at power-up enters a timed selection menu,
// otherwise the default image boots after the pre-boot hook completes.
module boot_selector #(
  parameter int N_IMG         = 4,
  parameter int IMG_DEFAULT   = 2,
  parameter int IMG_SEL_START = 1,
  parameter int SKIP_IMG      = 0,
  parameter int TMR_W         = 24,
  parameter int TIMEOUT_BIT   = 23,
  parameter int REARM_BIT     = 17,
  parameter int LED_BIT       = 21
) (
  input logic            clk,
  input logic            rst,
  boot_selector_if.slave bus
);

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_WAIT     = 3'd1,
    ST_SEL      = 3'd2,
    ST_SEL_WAIT = 3'd3,
    ST_HOOK     = 3'd4,
    ST_BOOT     = 3'd5
  } state_t;

  localparam logic [1:0] SEL_LAST  = 2'(N_IMG - 1);
  localparam logic [1:0] SEL_DEF   = 2'(IMG_DEFAULT);
  localparam logic [1:0] SEL_FIRST = 2'(IMG_SEL_START);
  localparam logic [1:0] SEL_SKIP  = 2'(SKIP_IMG);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [1:0]       boot_sel;
  logic             skip;
  logic             boot_req;
  logic             tick;
  logic             enter_hook;

  // SEL_WAIT uses the short re-arm period so a new press is accepted soon after release.
  assign tick = (state == ST_SEL_WAIT) ? timer[REARM_BIT] : timer[TIMEOUT_BIT];

  assign enter_hook = ((state == ST_START) && bus.btn_val) ||
                      ((state == ST_SEL) && tick && !bus.btn_fall && !skip);

  // Gated by rst so a reset asserted while the entry condition holds cannot emit a pulse.
  assign bus.hook_go    = enter_hook && !rst;
  assign bus.boot_req   = boot_req;
  assign bus.boot_sel   = boot_sel;
  assign bus.state_dbg  = state;
  assign bus.sel_active = (state == ST_WAIT) || (state == ST_SEL) || (state == ST_SEL_WAIT);
  assign bus.led        = (state == ST_WAIT) || (state == ST_SEL_WAIT) ||
                          ((state == ST_SEL) && timer[LED_BIT]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_START;
      timer    <= '0;
      boot_sel <= SEL_DEF;
      skip     <= 1'b0;
      boot_req <= 1'b0;
    end else begin
      // A held button keeps the timer at zero, postponing any timeout.
      timer    <= (!bus.btn_val || tick) ? '0 : timer + TMR_W'(1);
      boot_req <= (state == ST_BOOT);
      case (state)
        ST_START: state <= bus.btn_val ? ST_HOOK : ST_WAIT;
        ST_WAIT: begin
          boot_sel <= SEL_FIRST;
          if (bus.btn_val) state <= ST_SEL_WAIT;
        end
        ST_SEL_WAIT: if (tick) state <= ST_SEL;
        ST_SEL: begin
          if (bus.btn_fall) begin
            if (boot_sel == SEL_SKIP) skip <= 1'b1;
            boot_sel <= (boot_sel == SEL_LAST) ? 2'd0 : boot_sel + 2'd1;
            state    <= ST_SEL_WAIT;
          end else if (tick) begin
            state <= skip ? ST_BOOT : ST_HOOK;
          end
        end
        ST_HOOK: if (bus.hook_rdy) state <= ST_BOOT;
        ST_BOOT: state <= ST_BOOT;
        default: state <= ST_START;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_selector.sv
// Bench for boot_selector: directed boot-flow scenarios plus randomized button/hook/reset
// traffic, every cycle compared against a behavioural model of the selection rules.
module tb_boot_selector;
  localparam int N_IMG = 3, TMR_W = 8, TIMEOUT_BIT = 7, REARM_BIT = 3, LED_BIT = 5;
  localparam int IMG_DEFAULT = 2, IMG_SEL_START = 1, SKIP_IMG = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  boot_selector_if bus();

  boot_selector #(
    .N_IMG(N_IMG), .IMG_DEFAULT(IMG_DEFAULT), .IMG_SEL_START(IMG_SEL_START),
    .SKIP_IMG(SKIP_IMG), .TMR_W(TMR_W), .TIMEOUT_BIT(TIMEOUT_BIT),
    .REARM_BIT(REARM_BIT), .LED_BIT(LED_BIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];
  logic last_hook;
  int   hook_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases of the boot flow; the timer is plain integer arithmetic modulo 2**TMR_W.
  localparam int P_START = 0, P_WAIT = 1, P_SEL = 2, P_SELW = 3, P_HOOK = 4, P_BOOT = 5;
  int m_ph, m_t, m_sel;
  bit m_skip, m_breq;

  function automatic int bit_of(input int v, input int b);
    return (v >> b) & 1;
  endfunction

  task automatic model_reset();
    m_ph = P_START; m_t = 0; m_sel = IMG_DEFAULT; m_skip = 0; m_breq = 0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input bit bv, input bit bf, input bit hr, input bit r);
    logic [5:0] exp_v, got;
    int  tick;
    bit  e_hook, e_act, e_led;
    @(negedge clk);
    rst = r;
    bus.btn_val = bv; bus.btn_fall = bf; bus.hook_rdy = hr;
    #1;
    if (r) model_reset();
    tick   = (m_ph == P_SELW) ? bit_of(m_t, REARM_BIT) : bit_of(m_t, TIMEOUT_BIT);
    e_hook = !r && ((m_ph == P_START && bv) || (m_ph == P_SEL && tick == 1 && !bf && !m_skip));
    e_act  = (m_ph == P_WAIT) || (m_ph == P_SEL) || (m_ph == P_SELW);
    e_led  = (m_ph == P_WAIT) || (m_ph == P_SELW) || (m_ph == P_SEL && bit_of(m_t, LED_BIT) == 1);
    exp_q.push_back({e_hook, m_breq, 2'(m_sel), e_act, e_led});
    got   = {bus.hook_go, bus.boot_req, bus.boot_sel, bus.sel_active, bus.led};
    exp_v = exp_q.pop_front();
    check_eq("hook_go",    got[5],   exp_v[5]);
    check_eq("boot_req",   got[4],   exp_v[4]);
    check_eq("boot_sel",   got[3:2], exp_v[3:2]);
    check_eq("sel_active", got[1],   exp_v[1]);
    check_eq("led",        got[0],   exp_v[0]);
    last_hook = bus.hook_go;
    if (bus.hook_go) hook_cnt++;
    if (!r) begin
      m_breq = (m_ph == P_BOOT);
      case (m_ph)
        P_START: m_ph = bv ? P_HOOK : P_WAIT;
        P_WAIT: begin
          m_sel = IMG_SEL_START;
          if (bv) m_ph = P_SELW;
        end
        P_SELW: if (tick == 1) m_ph = P_SEL;
        P_SEL: begin
          if (bf) begin
            if (m_sel == SKIP_IMG) m_skip = 1;
            m_sel = (m_sel + 1) % N_IMG;
            m_ph  = P_SELW;
          end else if (tick == 1) begin
            m_ph = m_skip ? P_BOOT : P_HOOK;
          end
        end
        P_HOOK: if (hr) m_ph = P_BOOT;
        default: ;
      endcase
      m_t = (!bv || tick == 1) ? 0 : (m_t + 1) % (1 << TMR_W);
    end
  endtask

  task automatic do_reset(input bit bv, input int n);
    repeat (n) cycle(bv, 1'b0, 1'b0, 1'b1);
    hook_cnt = 0;
  endtask

  task automatic press_release(input int hold, input int rel);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (hold) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (rel) cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Releases the button and counts cycles up to the first hook_go, bounded.
  task automatic released_until_hook(input int budget, output int lat);
    lat = -1;
    for (int n = 0; n < budget; n++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (last_hook) begin
        lat = n;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    bit lvl;
    int boot_age;
    bus.btn_val = 1'b1; bus.btn_fall = 1'b0; bus.hook_rdy = 1'b0;
    model_reset();
    hook_cnt = 0;

    // Released button from reset: immediate hook, then boot after hook_rdy.
    do_reset(1'b1, 2);
    check_eq("reset_boot_sel", bus.boot_sel, IMG_DEFAULT);
    check_eq("reset_boot_req", bus.boot_req, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("direct_hook_first", last_hook, 1);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("direct_boot_req_lag", bus.boot_req, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("direct_boot_req", bus.boot_req, 1);
    check_eq("direct_boot_sel", bus.boot_sel, 2);
    check_eq("direct_hook_count", hook_cnt, 1);

    // Held at reset, released, no press: timeout in SEL with the start image.
    do_reset(1'b0, 2);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    released_until_hook(400, lat);
    check_eq("timeout_latency", lat, 137);
    check_eq("timeout_boot_sel", bus.boot_sel, 1);

    // Three presses wrap 1->2->0->1; the press at image 0 arms skip.
    do_reset(1'b0, 2);
    repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    press_release(3, 20);
    check_eq("press1_sel", bus.boot_sel, 2);
    press_release(3, 20);
    check_eq("press2_sel", bus.boot_sel, 0);
    press_release(3, 200);
    check_eq("skip_boot_sel", bus.boot_sel, 1);
    check_eq("skip_boot_req", bus.boot_req, 1);
    check_eq("skip_no_hook", hook_cnt, 0);

    // Press in the exact cycle of the SEL timeout: press wins.
    do_reset(1'b0, 2);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (137) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("coincide_no_hook", hook_cnt, 0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("coincide_sel", bus.boot_sel, 2);
    check_eq("coincide_active", bus.sel_active, 1);

    // Reset while waiting in HOOK.
    do_reset(1'b1, 2);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("hook_rst_boot_req", bus.boot_req, 0);
    check_eq("hook_rst_boot_sel", bus.boot_sel, 2);
    check_eq("hook_rst_hook_go", bus.hook_go, 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("hook_rst_restart", last_hook, 1);

    // Button level held low in SEL postpones the timeout indefinitely.
    do_reset(1'b0, 2);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    hook_cnt = 0;
    repeat (1000) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("hold_no_hook", hook_cnt, 0);
    check_eq("hold_active", bus.sel_active, 1);
    released_until_hook(400, lat);
    check_eq("hold_release_latency", lat, 128);

    // Randomized traffic: button with press events, hook_rdy pulses, occasional resets.
    do_reset(1'b1, 2);
    lvl = 1'b1;
    boot_age = 0;
    for (int i = 0; i < 20000; i++) begin
      bit nl, bf, hr, r;
      nl = lvl;
      if ($urandom_range(0, 29) == 0) nl = ~lvl;
      bf = lvl && !nl;
      hr = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 999) == 0) || (boot_age > 60);
      cycle(nl, bf, hr, r);
      lvl = nl;
      boot_age = (m_ph == P_BOOT) ? boot_age + 1 : 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/boot_selector.md
BOOT_SELECTOR -- requirements
Module: boot_selector

Interface
REQ-001 Parameter N_IMG, default 4: number of selectable images (2..4).
REQ-002 Parameter IMG_DEFAULT, default 2: image booted when no selection is made.
REQ-003 Parameter IMG_SEL_START, default 1: image preselected on entry to select mode.
REQ-004 Parameter SKIP_IMG, default 0: index whose press event arms hook skip.
REQ-005 Parameter TMR_W, default 24: timer width in bits.
REQ-006 Parameter TIMEOUT_BIT, default 23: timer bit giving the selection timeout tick (< TMR_W).
REQ-007 Parameter REARM_BIT, default 17: timer bit giving the re-arm tick (< TIMEOUT_BIT).
REQ-008 Parameter LED_BIT, default 21: timer bit driving the select-mode blink (< TIMEOUT_BIT).
REQ-009 clk  input  1  system clock.
REQ-010 rst  input  1  reset, asynchronous, active-high.
REQ-011 btn_val  input  1  filtered button level; 1 = released, 0 = pressed.
REQ-012 btn_fall  input  1  single-cycle press event from the filter.
REQ-013 hook_go  output  1  single-cycle pulse starting the pre-boot hook sequence.
REQ-014 hook_rdy  input  1  pre-boot hook complete; level or pulse.
REQ-015 boot_req  output  1  warm-boot request.
REQ-016 boot_sel  output  2  selected image index.
REQ-017 sel_active  output  1  high while in WAIT, SEL or SEL_WAIT.
REQ-018 led  output  1  user indicator.

Function
REQ-019 States: START, WAIT, SEL, SEL_WAIT, HOOK, BOOT; registered, one transition per clk maximum.
REQ-020 START: btn_val=1 -> HOOK; btn_val=0 -> WAIT.
REQ-021 WAIT: boot_sel loads IMG_SEL_START every cycle in WAIT; btn_val=1 -> SEL_WAIT.
REQ-022 SEL_WAIT: on tick -> SEL; btn_fall ignored.
REQ-023 SEL on btn_fall: boot_sel increments, wrapping from N_IMG-1 to 0; next state SEL_WAIT.
REQ-024 SEL with btn_fall and tick in the same cycle: btn_fall wins, and the tick is discarded.
REQ-025 SEL on tick without btn_fall: skip flag set -> BOOT; skip flag clear -> HOOK.
REQ-026 Skip flag set on btn_fall in SEL while boot_sel==SKIP_IMG.
REQ-027 Skip flag is sticky until rst.
REQ-028 HOOK: hook_go=1 exactly in the cycle the FSM transitions into HOOK (combinational on next state), never otherwise.
REQ-029 HOOK: hook_rdy=1 -> BOOT; hook_rdy is ignored in all other states.
REQ-030 BOOT is terminal; boot_sel is frozen.
REQ-031 boot_req = registered (state==BOOT): it rises 1 clk after BOOT entry and stays high.
REQ-032 Timer is TMR_W-bit and increments every clk.
REQ-033 Timer clears synchronously when btn_val=0 or tick=1.
REQ-034 tick = timer[REARM_BIT] in SEL_WAIT, else timer[TIMEOUT_BIT].
REQ-035 A held button therefore postpones the timeout indefinitely.
REQ-036 led: 1 in WAIT and SEL_WAIT; timer[LED_BIT] in SEL; 0 in START, HOOK and BOOT.

Reset
REQ-037 On rst: state=START, boot_sel=IMG_DEFAULT, skip=0, timer=0, boot_req=0, hook_go=0, led=0.
REQ-038 Reset asserted mid-HOOK or mid-SEL returns to START with no hook_go or boot_req glitch.
REQ-039 Deassertion restarts the flow from START.

Verification (N_IMG=3, TMR_W=8, TIMEOUT_BIT=7, REARM_BIT=3, LED_BIT=5)
REQ-040 btn_val=1 from reset -> hook_go one pulse at cycle 1; hook_rdy 5 clk later -> boot_req=1 next clk, boot_sel=2.
REQ-041 btn_val=0 at reset, release after 10 clk, no press -> SEL_WAIT 8 clk, SEL 128 clk, hook_go, boot_sel=1.
REQ-042 Three presses in SEL -> boot_sel 1->2->0->1 (wrap at 2); skip armed on the press at 0; timeout -> BOOT with no hook_go.
REQ-043 Press coincident with the tick in SEL -> stays in selection, boot_sel increments, no hook_go.
REQ-044 rst pulse while in HOOK before hook_rdy -> START, boot_req=0, skip=0, boot_sel=2.
REQ-045 btn_val held 0 for 1000 clk in SEL -> no timeout; release -> timeout 128 clk later.
